// File: rtl/pipe_prefix_adder.sv
// Pipelined Kogge-Stone KPG adder/subtractor with a global valid/ready stall.
// Define PIPE_PREFIX_ADDER_FLAGS_EN to build the ovf/zero flag logic.
module pipe_prefix_adder #(
  parameter int WIDTH       = 32,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int LV   = $clog2(WIDTH);
  localparam int S    = PIPE_STAGES;
  localparam int BASE = LV / S;
  localparam int REM  = LV % S;

  // Apply prefix levels lo..lo+n-1; a P node takes its lower neighbour.
  function automatic logic [2*WIDTH-1:0] levels(
    input logic [WIDTH-1:0] g_in,
    input logic [WIDTH-1:0] p_in,
    input int               lo,
    input int               n
  );
    logic [WIDTH-1:0] g, p, ng, np;
    g = g_in;
    p = p_in;
    for (int k = 0; k < LV; k++) begin
      if (k >= lo && k < lo + n) begin
        ng = g;
        np = p;
        for (int i = (1 << k); i < WIDTH; i++) begin
          if (p[i]) begin
            ng[i] = g[i - (1 << k)];
            np[i] = p[i - (1 << k)];
          end
        end
        g = ng;
        p = np;
      end
    end
    return {g, p};
  endfunction

  logic             v_q  [S];
  logic [WIDTH-1:0] g_q  [S];
  logic [WIDTH-1:0] p_q  [S];
  logic [WIDTH-1:0] x_q  [S];
  logic             c0_q [S];
  logic [WIDTH-1:0] g_n  [S];
  logic [WIDTH-1:0] p_n  [S];

  logic [WIDTH-1:0] bm;
  logic [WIDTH-1:0] g_d, p_d, x_d;
  logic             ce;
  logic             advance;
  logic [WIDTH:0]   c;

  // Bit 0 absorbs the virtual carry-in node, so the tree never ends on P.
  always_comb begin
    bm  = b ^ {WIDTH{sub}};
    ce  = cin | sub;
    x_d = a ^ bm;
    g_d = a & bm;
    p_d = x_d;
    if (p_d[0]) begin
      g_d[0] = ce;
      p_d[0] = 1'b0;
    end
  end

  for (genvar r = 0; r < S; r++) begin : g_rank
    localparam int N  = BASE + ((r < REM) ? 1 : 0);
    localparam int LO = r * BASE + ((r < REM) ? r : REM);
    assign {g_n[r], p_n[r]} = levels(g_q[r], p_q[r], LO, N);
  end

  assign out_valid = v_q[S-1];
  assign advance   = ~out_valid | out_ready;
  assign in_ready  = advance;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < S; r++) begin
        v_q[r]  <= 1'b0;
        g_q[r]  <= '0;
        p_q[r]  <= '0;
        x_q[r]  <= '0;
        c0_q[r] <= 1'b0;
      end
    end else if (advance) begin
      v_q[0]  <= in_valid;
      g_q[0]  <= g_d;
      p_q[0]  <= p_d;
      x_q[0]  <= x_d;
      c0_q[0] <= ce;
      for (int r = 1; r < S; r++) begin
        v_q[r]  <= v_q[r-1];
        g_q[r]  <= g_n[r-1];
        p_q[r]  <= p_n[r-1];
        x_q[r]  <= x_q[r-1];
        c0_q[r] <= c0_q[r-1];
      end
    end
  end

  assign c = {g_n[S-1] | (p_n[S-1] & {WIDTH{c0_q[S-1]}}),
              c0_q[S-1]};
  assign sum  = x_q[S-1] ^ c[WIDTH-1:0];
  assign cout = c[WIDTH];

`ifdef PIPE_PREFIX_ADDER_FLAGS_EN
  logic a_msb_q [S];
  logic bm_msb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < S; r++) a_msb_q[r] <= 1'b0;
    end else if (advance) begin
      a_msb_q[0] <= a[WIDTH-1];
      for (int r = 1; r < S; r++) a_msb_q[r] <= a_msb_q[r-1];
    end
  end

  assign bm_msb = x_q[S-1][WIDTH-1] ^ a_msb_q[S-1];
  assign ovf    = (a_msb_q[S-1] == bm_msb) &
                  (sum[WIDTH-1] != a_msb_q[S-1]);
  assign zero   = ~|sum;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_prefix_adder.sv
// Scoreboard bench for pipe_prefix_adder, six depths side by side.
// Flag expectations follow PIPE_PREFIX_ADDER_FLAGS_EN.
module tb_pipe_prefix_adder;

  localparam int W  = 32;
  localparam int ND = 6;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic [31:0]  cyc;
  } exp_t;

  logic         clk, rst, in_valid, out_ready, cin, sub;
  logic [W-1:0] a, b;
  logic         in_ready  [ND];
  logic         out_valid [ND];
  logic [W-1:0] sum       [ND];
  logic         cout      [ND];
  logic         ovf       [ND];
  logic         zero      [ND];

  int          cmp_n, err_n;
  logic [31:0] cyc;
  exp_t        q[$];

  for (genvar s = 0; s < ND; s++) begin : g_dut
    pipe_prefix_adder #(
      .WIDTH       (W),
      .PIPE_STAGES (s + 1)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready[s]),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid[s]),
      .out_ready (out_ready),
      .sum       (sum[s]),
      .cout      (cout[s]),
      .ovf       (ovf[s]),
      .zero      (zero[s])
    );
  end

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic exp_t model(input logic [W-1:0] ai,
                                 input logic [W-1:0] bi,
                                 input logic ci, input logic si,
                                 input logic [31:0] c);
    exp_t         e;
    logic [W-1:0] bm;
    logic [W:0]   t;
    bm = si ? ~bi : bi;
    t  = {1'b0, ai} + {1'b0, bm} + {{W{1'b0}}, ci | si};
    e.sum  = t[W-1:0];
    e.cout = t[W];
`ifdef PIPE_PREFIX_ADDER_FLAGS_EN
    e.ovf  = (ai[W-1] == bm[W-1]) && (t[W-1] != ai[W-1]);
    e.zero = (t[W-1:0] == '0);
`else
    e.ovf  = 1'b0;
    e.zero = 1'b0;
`endif
    e.cyc = c;
    return e;
  endfunction

  function automatic logic [W+2:0] obs(input int s);
    return {sum[s], cout[s], ovf[s], zero[s]};
  endfunction

  function automatic logic [W+2:0] expv(input exp_t e);
    return {e.sum, e.cout, e.ovf, e.zero};
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
    cyc = cyc + 1;
  endtask

  task automatic do_reset;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    rst = 1'b1;
    tick;
    tick;
    rst = 1'b0;
    q.delete();
  endtask

  task automatic test_reset;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    for (int s = 0; s < ND; s++) begin
      cmp_n++;
      if ({out_valid[s], obs(s)} !== '0) begin
        err_n++;
        $display("FAIL reset_out[%0d]: got %h want 0",
                 s, {out_valid[s], obs(s)});
      end
    end
    tick;
    rst = 1'b0;
    #1;
    for (int s = 0; s < ND; s++) begin
      cmp_n++;
      if (in_ready[s] !== 1'b1) begin
        err_n++;
        $display("FAIL reset_in_ready[%0d]: got %b want 1",
                 s, in_ready[s]);
      end
    end
  endtask

  task automatic test_basic;
    localparam int T = 1;
    logic [W-1:0] va [5];
    logic [W-1:0] vb [5];
    logic         vc [5];
    logic         vs [5];
    exp_t         e;
    va[0] = 32'hFFFF_FFFF; vb[0] = 32'h1; vc[0] = 0; vs[0] = 0;
    va[1] = 32'h7FFF_FFFF; vb[1] = 32'h1; vc[1] = 0; vs[1] = 0;
    va[2] = 32'h5;         vb[2] = 32'h7; vc[2] = 0; vs[2] = 1;
    va[3] = 32'h0;         vb[3] = 32'h0; vc[3] = 1; vs[3] = 0;
    va[4] = 32'hA;         vb[4] = 32'h3; vc[4] = 1; vs[4] = 1;
    do_reset;
    for (int i = 0; i < 12; i++) begin
      if (i < 5) begin
        in_valid = 1'b1;
        a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (out_valid[T] && out_ready) begin
        cmp_n++;
        if (q.size() == 0) begin
          err_n++;
          $display("FAIL basic_extra: got %h want none", obs(T));
        end else begin
          e = q.pop_front();
          if (obs(T) !== expv(e)) begin
            err_n++;
            $display("FAIL basic_data: got %h want %h",
                     obs(T), expv(e));
          end
          cmp_n++;
          if (cyc !== e.cyc + 32'(T + 1)) begin
            err_n++;
            $display("FAIL basic_latency: got %0d want %0d",
                     cyc - e.cyc, T + 1);
          end
        end
      end
      if (in_valid && in_ready[T]) q.push_back(model(a, b, cin, sub, cyc));
      tick;
    end
    cmp_n++;
    if (q.size() != 0) begin
      err_n++;
      $display("FAIL basic_drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic test_back_to_back;
    int   ptr [ND];
    exp_t e;
    do_reset;
    for (int s = 0; s < ND; s++) ptr[s] = 0;
    for (int i = 0; i < 110; i++) begin
      if (i < 100) begin
        in_valid = 1'b1;
        a = $urandom; b = $urandom;
        cin = 1'($urandom_range(0, 1));
        sub = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      #1;
      for (int s = 0; s < ND; s++) begin
        if (out_valid[s]) begin
          cmp_n++;
          if (ptr[s] >= q.size()) begin
            err_n++;
            $display("FAIL b2b_extra[%0d]: got %h want none", s, obs(s));
          end else begin
            e = q[ptr[s]];
            ptr[s]++;
            if (obs(s) !== expv(e)) begin
              err_n++;
              $display("FAIL b2b_data[%0d]: got %h want %h",
                       s, obs(s), expv(e));
            end
            cmp_n++;
            if (cyc !== e.cyc + 32'(s + 1)) begin
              err_n++;
              $display("FAIL b2b_latency[%0d]: got %0d want %0d",
                       s, cyc - e.cyc, s + 1);
            end
          end
        end
      end
      if (in_valid) q.push_back(model(a, b, cin, sub, cyc));
      tick;
    end
    for (int s = 0; s < ND; s++) begin
      cmp_n++;
      if (ptr[s] != 100) begin
        err_n++;
        $display("FAIL b2b_count[%0d]: got %0d want 100", s, ptr[s]);
      end
    end
  endtask

  task automatic test_random_handshake;
    localparam int T = 2;
    exp_t         e;
    logic [W+2:0] held;
    logic         hold;
    do_reset;
    hold = 1'b0;
    held = '0;
    for (int i = 0; i < 400; i++) begin
      in_valid  = (i < 300) ? ($urandom_range(0, 3) != 0) : 1'b0;
      out_ready = (i < 300) ? ($urandom_range(0, 2) != 0) : 1'b1;
      a = $urandom; b = $urandom;
      cin = 1'($urandom_range(0, 1));
      sub = 1'($urandom_range(0, 1));
      #1;
      if (hold) begin
        cmp_n++;
        if (!out_valid[T] || obs(T) !== held) begin
          err_n++;
          $display("FAIL rnd_stable: got %b/%h want 1/%h",
                   out_valid[T], obs(T), held);
        end
      end
      if (out_valid[T] && out_ready) begin
        cmp_n++;
        if (q.size() == 0) begin
          err_n++;
          $display("FAIL rnd_extra: got %h want none", obs(T));
        end else begin
          e = q.pop_front();
          if (obs(T) !== expv(e)) begin
            err_n++;
            $display("FAIL rnd_data: got %h want %h", obs(T), expv(e));
          end
        end
      end
      hold = out_valid[T] && !out_ready;
      held = obs(T);
      if (in_valid && in_ready[T]) q.push_back(model(a, b, cin, sub, cyc));
      tick;
    end
    cmp_n++;
    if (q.size() != 0) begin
      err_n++;
      $display("FAIL rnd_drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic test_fill;
    localparam int T = 2;
    exp_t e;
    int   acc;
    do_reset;
    out_ready = 1'b0;
    acc = 0;
    cin = 1'b0;
    sub = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = $urandom; b = $urandom;
      #1;
      if (i >= 3) begin
        cmp_n++;
        if (in_ready[T] !== 1'b0) begin
          err_n++;
          $display("FAIL fill_ready: got %b want 0", in_ready[T]);
        end
      end
      if (in_valid && in_ready[T]) begin
        acc++;
        q.push_back(model(a, b, cin, sub, cyc));
      end
      tick;
    end
    cmp_n++;
    if (acc != 3) begin
      err_n++;
      $display("FAIL fill_count: got %0d want 3", acc);
    end
    for (int i = 0; i < 9; i++) begin
      out_ready = 1'b1;
      in_valid  = (i == 0);
      a = $urandom; b = $urandom;
      #1;
      if (i == 0) begin
        cmp_n++;
        if (in_ready[T] !== 1'b1) begin
          err_n++;
          $display("FAIL release_ready: got %b want 1", in_ready[T]);
        end
      end
      if (out_valid[T] && out_ready) begin
        cmp_n++;
        if (q.size() == 0) begin
          err_n++;
          $display("FAIL fill_extra: got %h want none", obs(T));
        end else begin
          e = q.pop_front();
          if (obs(T) !== expv(e)) begin
            err_n++;
            $display("FAIL fill_data: got %h want %h", obs(T), expv(e));
          end
        end
      end
      if (in_valid && in_ready[T]) q.push_back(model(a, b, cin, sub, cyc));
      tick;
    end
    cmp_n++;
    if (q.size() != 0) begin
      err_n++;
      $display("FAIL fill_drain: got %0d left want 0", q.size());
    end
  endtask

  task automatic test_reset_mid;
    localparam int T = 1;
    exp_t e;
    do_reset;
    cin = 1'b0;
    sub = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      a = $urandom | 32'h1; b = $urandom;
      tick;
    end
    in_valid = 1'b0;
    #1;
    cmp_n++;
    if (out_valid[T] !== 1'b1) begin
      err_n++;
      $display("FAIL mid_inflight: got %b want 1", out_valid[T]);
    end
    rst = 1'b1;
    #1;
    cmp_n++;
    if ({out_valid[T], obs(T)} !== '0) begin
      err_n++;
      $display("FAIL mid_rst_out: got %h want 0", {out_valid[T], obs(T)});
    end
    tick;
    rst = 1'b0;
    q.delete();
    in_valid = 1'b1;
    a = 32'd3; b = 32'd4;
    #1;
    if (in_valid && in_ready[T]) q.push_back(model(a, b, cin, sub, cyc));
    tick;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1;
      if (out_valid[T] && out_ready) begin
        cmp_n++;
        if (q.size() == 0) begin
          err_n++;
          $display("FAIL mid_stale: got %h want none", obs(T));
        end else begin
          e = q.pop_front();
          if (obs(T) !== expv(e) || e.sum !== 32'd7) begin
            err_n++;
            $display("FAIL mid_data: got %h want %h", obs(T), expv(e));
          end
          cmp_n++;
          if (cyc !== e.cyc + 32'(T + 1)) begin
            err_n++;
            $display("FAIL mid_latency: got %0d want %0d",
                     cyc - e.cyc, T + 1);
          end
        end
      end
      tick;
    end
    cmp_n++;
    if (q.size() != 0) begin
      err_n++;
      $display("FAIL mid_drain: got %0d left want 0", q.size());
    end
  endtask

  initial begin
    cmp_n = 0;
    err_n = 0;
    cyc   = '0;
    rst   = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    tick;
    test_reset;
    test_basic;
    test_back_to_back;
    test_random_handshake;
    test_fill;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
